// File: rtl/xpb_table_gen_pkg.sv
// Shared definitions for the XPB reduction-table generator and its table readers.
//   XPB_WIDTH    : entry / operand width in bits
//   XPB_IDX_BITS : table index width (table holds 2^XPB_IDX_BITS entries)
//   xpb_idx_t    : entry index type, shared with the table readers
//   xpb_state_t  : generator sequencing states
package xpb_table_gen_pkg;

    localparam int unsigned XPB_WIDTH    = 1024;
    localparam int unsigned XPB_IDX_BITS = 5;
    localparam int unsigned XPB_ENTRIES  = 1 << XPB_IDX_BITS;

    typedef logic [XPB_IDX_BITS-1:0] xpb_idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ZERO,
        S_ADD,
        S_RED
    } xpb_state_t;

endpackage

// File: rtl/xpb_table_gen_if.sv
// Request / table-write bus of the XPB table generator.
//   master : requester side; drives start, base, modulus and observes status and writes
//   slave  : generator side; samples the request and drives busy, the write port, done, err
interface xpb_table_gen_if
    import xpb_table_gen_pkg::*;
#(
    parameter int unsigned WIDTH    = XPB_WIDTH,
    parameter int unsigned IDX_BITS = XPB_IDX_BITS
);

    logic                start;
    logic [WIDTH-1:0]    base;
    logic [WIDTH-1:0]    modulus;
    logic                busy;
    logic                wr_en;
    logic [IDX_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                done;
    logic                err;

    modport master (
        output start, base, modulus,
        input  busy, wr_en, wr_addr, wr_data, done, err
    );

    modport slave (
        input  start, base, modulus,
        output busy, wr_en, wr_addr, wr_data, done, err
    );

endinterface

// File: rtl/xpb_mod_add.sv
// Combinational modular add (a + b) mod n for a, b < n, split into two halves so a
// caller can register the raw sum between them.
//   i_a, i_b  : addends, both < i_n
//   i_n       : modulus
//   o_sum_c   : raw WIDTH+1-bit sum i_a + i_b
//   i_sum     : sum to reduce (tie to o_sum_c for a single-cycle modular add)
//   o_res_c   : i_sum mod i_n, valid for i_sum < 2*i_n
module xpb_mod_add
    import xpb_table_gen_pkg::*;
#(
    parameter int unsigned WIDTH = XPB_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH:0]   i_sum,
    output logic [WIDTH:0]   o_sum_c,
    output logic [WIDTH-1:0] o_res_c
);

    logic [WIDTH:0] w_n_ext;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Add half: full-width carry kept in bit WIDTH.
    assign o_sum_c = {1'b0, i_a} + {1'b0, i_b};

    // Reduce half: one conditional subtract suffices because i_sum < 2*i_n.
    assign w_n_ext = {1'b0, i_n};
    assign w_diff  = i_sum - w_n_ext;
    assign w_ge    = (i_sum >= w_n_ext);
    assign o_res_c = WIDTH'(w_ge ? w_diff : i_sum);

endmodule

// File: rtl/xpb_table_gen.sv
// XPB reduction-table writer: for a latched base B and modulus N, streams
// entry[j] = j*B mod N for j = 0..2^IDX_BITS-1 onto a table write port,
// one entry every two cycles (ADD then RED).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of xpb_table_gen_if
//                start/base/modulus in; busy, wr_en/wr_addr/wr_data, done, err out
module xpb_table_gen
    import xpb_table_gen_pkg::*;
#(
    parameter int unsigned WIDTH    = XPB_WIDTH,
    parameter int unsigned IDX_BITS = XPB_IDX_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    xpb_table_gen_if.slave    bus
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

    xpb_state_t          r_state;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_n;
    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH:0]      r_sum;
    logic [IDX_BITS-1:0] r_idx;
    logic                r_busy;
    logic                r_wr_en;
    logic [IDX_BITS-1:0] r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic                r_done;
    logic                r_err;

    logic                w_start_ok;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_sel;

    // A run needs a nonzero modulus and a base already reduced below it.
    assign w_start_ok = (bus.modulus != '0) && (bus.base < bus.modulus);

    // acc + B feeds the ADD stage; the registered sum is reduced in RED.
    xpb_mod_add #(
        .WIDTH (WIDTH)
    ) u_mod_add (
        .i_a     (r_acc),
        .i_b     (r_b),
        .i_n     (r_n),
        .i_sum   (r_sum),
        .o_sum_c (w_sum),
        .o_res_c (w_sel)
    );

    // Sequencer with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_b       <= '0;
            r_n       <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        if (w_start_ok) begin
                            r_b     <= bus.base;
                            r_n     <= bus.modulus;
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_ZERO;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ZERO: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= '0;
                    r_wr_data <= '0;
                    r_idx     <= IDX_BITS'(1);
                    r_state   <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= w_sum;
                    r_state <= S_RED;
                end
                S_RED: begin
                    r_acc     <= w_sel;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_idx;
                    r_wr_data <= w_sel;
                    // busy stays high here and drops on the following IDLE cycle.
                    if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + IDX_BITS'(1);
                        r_state <= S_ADD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.done    = r_done;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen: table contents, write/done/busy timing,
// rejected starts, ignored restarts, mid-run reset and the sum==N boundary.
module tb_xpb_table_gen;
    import xpb_table_gen_pkg::*;

    localparam int unsigned W       = XPB_WIDTH;
    localparam int unsigned IB      = XPB_IDX_BITS;
    localparam int          NENT    = 1 << XPB_IDX_BITS;
    localparam int          LAST_E  = 2 * NENT - 1;
    localparam int          CAP_MAX = 80;

    logic clk;
    logic rst_n;

    int errors;
    int checks;

    logic         cap_en   [0:CAP_MAX-1];
    xpb_idx_t     cap_addr [0:CAP_MAX-1];
    logic [W-1:0] cap_data [0:CAP_MAX-1];
    logic         cap_done [0:CAP_MAX-1];
    logic         cap_busy [0:CAP_MAX-1];
    logic         cap_err  [0:CAP_MAX-1];

    xpb_table_gen_if bus ();

    xpb_table_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sample(input int e);
        cap_en[e]   = bus.wr_en;
        cap_addr[e] = bus.wr_addr;
        cap_data[e] = bus.wr_data;
        cap_done[e] = bus.done;
        cap_busy[e] = bus.busy;
        cap_err[e]  = bus.err;
    endtask

    // Pulse start so it is taken at edge 0, then record outputs #1 after edges 0..n_edges.
    // With inject set, start is re-raised at edges 10 and 20 with different operands.
    task automatic capture(input logic [W-1:0] b, input logic [W-1:0] n,
                           input bit inject, input int n_edges);
        bus.base    = b;
        bus.modulus = n;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        sample(0);
        for (int e = 1; e <= n_edges; e++) begin
            if (inject && (e == 10 || e == 20)) begin
                bus.start   = 1'b1;
                bus.base    = W'(7);
                bus.modulus = W'(11);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            sample(e);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.busy    !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.wr_en   !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); end
        checks++; if (bus.done    !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
        checks++; if (bus.err     !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err); end
        checks++; if (bus.wr_addr !== '0)   begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); end
        checks++; if (bus.wr_data !== '0)   begin errors++; $display("FAIL reset_wr_data: got %0h want 0", bus.wr_data[63:0]); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%0b wr_en=%0b want 0 0", bus.busy, bus.wr_en);
        end
    endtask

    task automatic test_basic();
        int exp_hand [14] = '{0, 5, 10, 2, 7, 12, 4, 9, 1, 6, 11, 3, 8, 0};
        int exp_v;
        capture(W'(5), W'(13), 1'b0, 66);
        checks++; if (cap_busy[0] !== 1'b1 || cap_en[0] !== 1'b0 || cap_err[0] !== 1'b0) begin
            errors++; $display("FAIL basic_accept: busy=%0b wr_en=%0b err=%0b want 1 0 0", cap_busy[0], cap_en[0], cap_err[0]);
        end
        for (int j = 0; j < NENT; j++) begin
            exp_v = (j < 14) ? exp_hand[j] : (j * 5) % 13;
            checks++;
            if (cap_en[1+2*j] !== 1'b1 || cap_addr[1+2*j] !== IB'(j) || cap_data[1+2*j] !== W'(exp_v)) begin
                errors++;
                $display("FAIL basic_entry%0d: en=%0b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                         j, cap_en[1+2*j], cap_addr[1+2*j], cap_data[1+2*j][63:0], j, exp_v);
            end
        end
        for (int e = 1; e <= LAST_E + 1; e++) begin
            checks++;
            if ((e % 2 == 0 && cap_en[e] !== 1'b0) || cap_done[e] !== (e == LAST_E) || cap_busy[e] !== (e <= LAST_E)) begin
                errors++;
                $display("FAIL basic_timing_edge%0d: en=%0b done=%0b busy=%0b want en=%0b done=%0b busy=%0b",
                         e, cap_en[e], cap_done[e], cap_busy[e], (e % 2), (e == LAST_E), (e <= LAST_E));
            end
        end
    endtask

    task automatic test_max_width();
        logic [W-1:0] n;
        logic [W-1:0] exp_v;
        logic [W-1:0] lit31;
        n     = '1;
        lit31 = {{(W-5){1'b1}}, 5'b00000};
        capture(n - W'(1), n, 1'b0, 66);
        for (int j = 0; j < NENT; j++) begin
            exp_v = (j == 0) ? '0 : n - W'(j);
            checks++;
            if (cap_en[1+2*j] !== 1'b1 || cap_addr[1+2*j] !== IB'(j) || cap_data[1+2*j] !== exp_v) begin
                errors++;
                $display("FAIL maxw_entry%0d: en=%0b addr=%0d data_low64=%0h want en=1 addr=%0d data_low64=%0h",
                         j, cap_en[1+2*j], cap_addr[1+2*j], cap_data[1+2*j][63:0], j, exp_v[63:0]);
            end
        end
        checks++; if (cap_data[LAST_E] !== lit31) begin
            errors++; $display("FAIL maxw_addr31_literal: data_low64=%0h want %0h", cap_data[LAST_E][63:0], lit31[63:0]);
        end
        checks++; if (cap_done[LAST_E] !== 1'b1 || cap_busy[LAST_E+1] !== 1'b0) begin
            errors++; $display("FAIL maxw_done: done=%0b busy_after=%0b want 1 0", cap_done[LAST_E], cap_busy[LAST_E+1]);
        end
    endtask

    task automatic test_invalid();
        for (int c = 0; c < 2; c++) begin
            capture(W'((c == 0) ? 13 : 5), W'((c == 0) ? 13 : 0), 1'b0, 3);
            for (int e = 0; e <= 3; e++) begin
                checks++;
                if (cap_err[e] !== (e == 0) || cap_busy[e] !== 1'b0 || cap_en[e] !== 1'b0 || cap_done[e] !== 1'b0) begin
                    errors++;
                    $display("FAIL invalid%0d_edge%0d: err=%0b busy=%0b en=%0b done=%0b want err=%0b busy=0 en=0 done=0",
                             c, e, cap_err[e], cap_busy[e], cap_en[e], cap_done[e], (e == 0));
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int exp_v;
        capture(W'(5), W'(13), 1'b1, 66);
        for (int j = 0; j < NENT; j++) begin
            exp_v = (j * 5) % 13;
            checks++;
            if (cap_en[1+2*j] !== 1'b1 || cap_addr[1+2*j] !== IB'(j) || cap_data[1+2*j] !== W'(exp_v)) begin
                errors++;
                $display("FAIL restart_entry%0d: en=%0b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                         j, cap_en[1+2*j], cap_addr[1+2*j], cap_data[1+2*j][63:0], j, exp_v);
            end
        end
        checks++; if (cap_err[10] !== 1'b0 || cap_err[20] !== 1'b0 || cap_en[10] !== 1'b0 || cap_en[20] !== 1'b0) begin
            errors++; $display("FAIL restart_no_side_effect: err10=%0b err20=%0b en10=%0b en20=%0b want 0 0 0 0",
                               cap_err[10], cap_err[20], cap_en[10], cap_en[20]);
        end
        checks++; if (cap_done[LAST_E] !== 1'b1 || cap_busy[LAST_E+1] !== 1'b0) begin
            errors++; $display("FAIL restart_done: done=%0b busy_after=%0b want 1 0", cap_done[LAST_E], cap_busy[LAST_E+1]);
        end
    endtask

    task automatic test_reset_mid_run();
        int exp_v;
        capture(W'(5), W'(13), 1'b0, 20);
        checks++; if (cap_busy[20] !== 1'b1) begin
            errors++; $display("FAIL midrst_running: busy=%0b want 1", cap_busy[20]);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.wr_addr !== '0 || bus.wr_data !== '0) begin
            errors++;
            $display("FAIL midrst_async_clear: busy=%0b en=%0b done=%0b err=%0b addr=%0d data=%0h want all 0",
                     bus.busy, bus.wr_en, bus.done, bus.err, bus.wr_addr, bus.wr_data[63:0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL midrst_held%0d: en=%0b busy=%0b want 0 0", k, bus.wr_en, bus.busy);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(W'(5), W'(13), 1'b0, 66);
        for (int j = 0; j < NENT; j++) begin
            exp_v = (j * 5) % 13;
            checks++;
            if (cap_en[1+2*j] !== 1'b1 || cap_addr[1+2*j] !== IB'(j) || cap_data[1+2*j] !== W'(exp_v)) begin
                errors++;
                $display("FAIL midrst_rerun_entry%0d: en=%0b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                         j, cap_en[1+2*j], cap_addr[1+2*j], cap_data[1+2*j][63:0], j, exp_v);
            end
        end
        checks++; if (cap_done[LAST_E] !== 1'b1 || cap_busy[LAST_E+1] !== 1'b0) begin
            errors++; $display("FAIL midrst_rerun_done: done=%0b busy_after=%0b want 1 0", cap_done[LAST_E], cap_busy[LAST_E+1]);
        end
    endtask

    task automatic test_equality();
        int exp_v;
        capture(W'(5), W'(10), 1'b0, 66);
        for (int j = 0; j < NENT; j++) begin
            exp_v = (j % 2 == 0) ? 0 : 5;
            checks++;
            if (cap_en[1+2*j] !== 1'b1 || cap_addr[1+2*j] !== IB'(j) || cap_data[1+2*j] !== W'(exp_v)) begin
                errors++;
                $display("FAIL equal_entry%0d: en=%0b addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                         j, cap_en[1+2*j], cap_addr[1+2*j], cap_data[1+2*j][63:0], j, exp_v);
            end
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.base    = '0;
        bus.modulus = '0;
        test_reset();
        test_basic();
        test_max_width();
        test_invalid();
        test_start_ignored();
        test_reset_mid_run();
        test_equality();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
Name: xpb_table_gen

Overview:
- Runtime generator (writer) for the XPB reduction lookup tables that the modular-square datapath reads by 5-bit index.
- Given a base value B (= 2^k mod N for one table segment) and modulus N, computes entry[j] = j*B mod N for j = 0..2^IDX_BITS-1.
- Streams the entries out on a simple write port into a RAM-backed XPB table, so a table can be reloaded for a new modulus without regenerating constant ROMs.
- One modular add (add, then conditional subtract) per entry, two cycles per entry.

Parameters:
- WIDTH, 1024, operand/entry width in bits (matches the XPB entry width).
- IDX_BITS, 5, table index width; the table has 2^IDX_BITS entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base  in  WIDTH  B; sampled on the accepted start.
- modulus  in  WIDTH  N; sampled on the accepted start.
- busy  out  1  high while a generation run is in progress.
- wr_en  out  1  one-cycle write strobe for a table entry.
- wr_addr  out  IDX_BITS  entry index j.
- wr_data  out  WIDTH  entry value j*B mod N.
- done  out  1  one-cycle pulse, coincident with the final write.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. busy, wr_en, done, err = 0. wr_addr = 0, wr_data = 0. Internal acc, sum, idx, B, N registers are all cleared.
- All outputs are registered.
- States: IDLE, ZERO, ADD, RED.
- IDLE:
  - On start with N==0 or B>=N: pulse err for one cycle next cycle. State stays IDLE, no writes.
  - On start with valid operands: latch B and N, set acc=0 and idx=0, go to ZERO. busy=1 from the next cycle.
- ZERO: next edge drives wr_en=1, wr_addr=0, wr_data=0, then sets idx=1 and goes to ADD.
- ADD: sum (WIDTH+1 bits) <= acc + B. Go to RED.
- RED:
  - Compute diff = sum - N (WIDTH+1 bits). sel = (sum >= N) ? diff[WIDTH-1:0] : sum[WIDTH-1:0].
  - sum==N must yield 0.
  - acc <= sel. Drive wr_en=1, wr_addr=idx, wr_data=sel.
  - If idx == 2^IDX_BITS-1: done=1 in the same cycle, go to IDLE. busy drops the following cycle.
  - Otherwise idx++ and go to ADD.
- Timing: start accepted at edge 0. Entry j is written at edge 1+2j. For IDX_BITS=5, the last write and done occur at edge 63, and busy is low from edge 64.
- wr_en is never high on two consecutive cycles, except that the ZERO write and any later write are always separated by ADD.
- start while busy is ignored; the latched B and N stay stable for the whole run.
- Base or modulus changes after an accepted start have no effect.
- Deasserting rst_n mid-run aborts immediately. No further writes occur, and the partially written table is the consumer's concern.
- Arithmetic: a full WIDTH+1-bit add and a full WIDTH+1-bit subtract/compare per RED cycle. The invariant acc < N holds, which guarantees a single subtract suffices.

Decomposition:
- Shared package holds:
  - XPB_WIDTH = 1024 and XPB_IDX_BITS = 5.
  - The state enum {IDLE, ZERO, ADD, RED}.
  - The entry-index typedef, reused by the XPB table readers.
- One natural sub-module: xpb_mod_add. Combinational (a+b) mod n with a,b < n, WIDTH parameter. It is reused by other reduction-table generators.

Test Plan:
- N=13, B=5, start -> 32 writes at edges 1,3,...,63:
  - addr0..13 = 0,5,10,2,7,12,4,9,1,6,11,3,8,0, pattern continues j*5 mod 13.
  - done at edge 63; busy low at edge 64.
- N=2^1024-1, B=N-1 -> entry j = N-j for j>=1 (e.g. addr1 = 2^1024-2, addr31 = 2^1024-32); entry 0 = 0. Exercises the max-width carry into bit WIDTH.
- Invalid start: B=13, N=13 -> err pulse one cycle, no wr_en, busy stays 0. Repeat with N=0 -> same result.
- start re-asserted at edges 10 and 20 with different B during a run -> ignored; output sequence is identical to the clean run.
- rst_n low at edge 21 during a run -> all outputs 0 asynchronously, state IDLE. A new start with N=13, B=5 then produces the full correct sequence.
- Equality boundary: N=10, B=5 -> addr2 = 0 (sum==N case), addr3 = 5, alternating 0/5 for all even/odd addresses.
